captura_lineas: RTL and testbench

CAPTURA_LINEAS -- requirements
Module: captura_lineas

---
 rtl/captura_lineas_if.sv | 32 +++
 rtl/captura_lineas.sv | 83 ++++++++
 tb/tb_captura_lineas.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/captura_lineas_if.sv
// captura_lineas_if
//   Groups the request-line capture signals into one bundle.
//   lineas_in   : raw asynchronous request lines, bit i = line i
//   clr         : per-line pending clear strobe, synchronous, active-high
//   ocho_lineas : registered pending request vector (to the 8-line encoder)
//   irq         : OR of ocho_lineas
//   perdida     : sticky per-line "request lost while pending" flags
//   master : drives lineas_in/clr, observes the outputs (testbench / system)
//   slave  : the capture block itself
interface captura_lineas_if;
  logic [7:0] lineas_in;
  logic [7:0] clr;
  logic [7:0] ocho_lineas;
  logic       irq;
  logic [7:0] perdida;

  modport master (
    output lineas_in,
    output clr,
    input  ocho_lineas,
    input  irq,
    input  perdida
  );

  modport slave (
    input  lineas_in,
    input  clr,
    output ocho_lineas,
    output irq,
    output perdida
  );
endinterface

// File: rtl/captura_lineas.sv
// captura_lineas
//   Eight independent request lines: each is synchronized (2 flops),
//   debounced over DEB_CYCLES consecutive cycles, and its 0->1 debounced
//   transition latches a pending bit. A second rise while pending marks the
//   line as lost (perdida). clr clears both per line; a rise on the same edge
//   as clr wins for the pending bit and leaves perdida clear.
// Ports
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (release synchronized externally)
//   bus   : captura_lineas_if.slave (lineas_in, clr, ocho_lineas, irq, perdida)
// Parameter
//   DEB_CYCLES : debounce length in cycles, 1..255
module captura_lineas #(
  parameter int DEB_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  captura_lineas_if.slave     bus
);

  localparam int CNT_W = ($clog2(DEB_CYCLES + 1) < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [7:0]       s1_q, s2_q;
  logic [7:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [7:0]       ocho_q, ocho_d;
  logic [7:0]       perd_q, perd_d;
  logic [7:0]       rise;

  // Debounce: the counter tracks how long s2 has disagreed with the debounced
  // state; any agreement restarts it, so short glitches never reach deb.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // The rise is taken from the next-state value so the pending bit is set on
  // the very edge the debounced state flips.
  always_comb begin
    rise   = deb_d & ~deb_q;
    ocho_d = rise | (ocho_q & ~bus.clr);
    perd_d = (rise & ocho_q & ~bus.clr) | (perd_q & ~bus.clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      deb_q  <= '0;
      ocho_q <= '0;
      perd_q <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= bus.lineas_in;
      s2_q   <= s1_q;
      deb_q  <= deb_d;
      ocho_q <= ocho_d;
      perd_q <= perd_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.ocho_lineas = ocho_q;
  assign bus.irq         = |ocho_q;
  assign bus.perdida     = perd_q;

endmodule

// File: tb/tb_captura_lineas.sv
// tb_captura_lineas
//   Directed vectors for captura_lineas with DEB_CYCLES=4 (6-edge latency).
module tb_captura_lineas;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  captura_lineas_if bus_if ();

  captura_lineas #(.DEB_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    bus_if.lineas_in = 8'h00;
    bus_if.clr       = 8'h00;

    // Reset state
    step(2);
    chk("rst_ocho", bus_if.ocho_lineas, 8'h00);
    chk("rst_irq",  {7'd0, bus_if.irq}, 8'h00);
    chk("rst_perd", bus_if.perdida,     8'h00);
    rst_n = 1'b1;

    // Line 0 latency: 0 after 5 edges, set after the 6th
    bus_if.lineas_in = 8'h01;
    step(5);
    chk("lat0_before", bus_if.ocho_lineas, 8'h00);
    step(1);
    chk("lat0_ocho", bus_if.ocho_lineas, 8'h01);
    chk("lat0_irq",  {7'd0, bus_if.irq}, 8'h01);

    // Clear line 0, then 3-cycle glitch on line 3 is filtered
    bus_if.clr = 8'h01;
    step(1);
    bus_if.clr = 8'h00;
    chk("clr0_ocho", bus_if.ocho_lineas, 8'h00);
    bus_if.lineas_in = 8'h09;
    step(3);
    bus_if.lineas_in = 8'h01;
    step(10);
    chk("glitch_ocho", bus_if.ocho_lineas, 8'h00);
    chk("glitch_perd", bus_if.perdida,     8'h00);

    // Line 5 pending, release and re-press -> lost
    bus_if.lineas_in = 8'h20;
    step(10);
    chk("l5_first", bus_if.ocho_lineas, 8'h20);
    bus_if.lineas_in = 8'h00;
    step(10);
    bus_if.lineas_in = 8'h20;
    step(10);
    chk("l5_ocho", bus_if.ocho_lineas, 8'h20);
    chk("l5_perd", bus_if.perdida,     8'h20);
    bus_if.clr = 8'h20;
    step(1);
    bus_if.clr = 8'h00;
    chk("l5_clr_ocho", bus_if.ocho_lineas, 8'h00);
    chk("l5_clr_perd", bus_if.perdida,     8'h00);
    chk("l5_clr_irq",  {7'd0, bus_if.irq}, 8'h00);

    // All lines at once, partial clear
    bus_if.lineas_in = 8'h00;
    step(10);
    bus_if.lineas_in = 8'hFF;
    step(5);
    chk("all_before", bus_if.ocho_lineas, 8'h00);
    step(1);
    chk("all_ocho", bus_if.ocho_lineas, 8'hFF);
    chk("all_perd", bus_if.perdida,     8'h00);
    bus_if.clr = 8'h0F;
    step(1);
    bus_if.clr = 8'h00;
    chk("part_clr_ocho", bus_if.ocho_lineas, 8'hF0);
    chk("part_clr_irq",  {7'd0, bus_if.irq}, 8'h01);
    bus_if.clr = 8'hFF;
    step(1);
    bus_if.clr = 8'h00;
    chk("full_clr_ocho", bus_if.ocho_lineas, 8'h00);

    // Line 2: pending, then re-rise on the same edge as clr -> set wins, perdida clear
    bus_if.lineas_in = 8'h00;
    step(10);
    bus_if.lineas_in = 8'h04;
    step(10);
    chk("l2_pend", bus_if.ocho_lineas, 8'h04);
    bus_if.lineas_in = 8'h00;
    step(10);
    bus_if.lineas_in = 8'h04;
    step(5);
    bus_if.clr = 8'h04;
    step(1);
    bus_if.clr = 8'h00;
    chk("setwin_ocho", bus_if.ocho_lineas, 8'h04);
    chk("setwin_perd", bus_if.perdida,     8'h00);

    // Line 7 debounce interrupted by asynchronous reset
    bus_if.lineas_in = 8'h80;
    step(4);
    chk("pre_rst_ocho", bus_if.ocho_lineas, 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ocho", bus_if.ocho_lineas, 8'h00);
    chk("async_irq",  {7'd0, bus_if.irq}, 8'h00);
    chk("async_perd", bus_if.perdida,     8'h00);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("release_ocho", bus_if.ocho_lineas, 8'h00);
    step(4);
    chk("l7_before", bus_if.ocho_lineas, 8'h00);
    step(1);
    chk("l7_ocho", bus_if.ocho_lineas, 8'h80);
    chk("l7_irq",  {7'd0, bus_if.irq}, 8'h01);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
